// File: rtl/operand_sweep.sv
// -----------------------------------------------------------------------------
// operand_sweep
//
// Walks a sequence of operands through an external add-one stage and checks
// each result. Starting at SEED, each sweep presents COUNT operands spaced by
// STRIDE (modulo 2^WIDTH). Each operand is held for a DRIVE cycle, so the
// external combinational stage can settle. It is then checked in a CHECK
// cycle, so each operand takes two cycles. The block counts the mismatches
// and records the operand of the first one.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin a sweep (only honoured in IDLE)
//   x            out  WIDTH  registered operand to the add-one stage
//   y            in   WIDTH  add-one stage result for x
//   busy         out  1      high while operands are being driven/checked
//   done         out  1      one-cycle pulse when a sweep completes
//   pass         out  1      last completed sweep had no mismatches
//   err_count    out  16     saturating mismatch count of current/last sweep
//   first_bad_x  out  WIDTH  operand of the first mismatch of the sweep
// -----------------------------------------------------------------------------
module operand_sweep #(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 17,
  parameter int COUNT  = 256,
  parameter int SEED   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] first_bad_x
);

  localparam logic [WIDTH-1:0] SEED_V    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] STRIDE_V  = WIDTH'(STRIDE);
  localparam logic [15:0]      LAST_STEP = 16'(COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [15:0]      r_step;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err;
  logic [WIDTH-1:0] r_first_bad;

  // The expected result wraps naturally at WIDTH bits.
  logic [WIDTH-1:0] w_expect;
  logic             w_mismatch;
  logic             w_last;

  assign w_expect   = r_x + WIDTH'(1);
  assign w_mismatch = (y != w_expect);
  assign w_last     = (r_step == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= SEED_V;
      r_step      <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= 16'd0;
      r_first_bad <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x         <= SEED_V;
            r_step      <= 16'd0;
            r_err       <= 16'd0;
            r_first_bad <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_DRIVE;
          end
        end

        // x is held for this cycle so that y settles before it is checked.
        S_DRIVE: r_state <= S_CHECK;

        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != 16'hFFFF) begin
              r_err <= r_err + 16'd1;
            end
            // An error count of zero before the increment marks the first
            // mismatch of this sweep.
            if (r_err == 16'd0) begin
              r_first_bad <= r_x;
            end
          end
          if (w_last) begin
            // done is raised here so that it is high for the whole DONE cycle.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x     <= r_x + STRIDE_V;
            r_step  <= r_step + 16'd1;
            r_state <= S_DRIVE;
          end
        end

        S_DONE: begin
          // r_err already includes the final check of this sweep.
          r_pass  <= (r_err == 16'd0);
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x           = r_x;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_count   = r_err;
  assign first_bad_x = r_first_bad;

endmodule

// File: doc/operand_sweep.md
OPERAND_SWEEP -- requirements
Module: operand_sweep

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result width in bits.
REQ-002 Parameter STRIDE, default 17, SHALL set the increment between successive operands.
REQ-003 Parameter COUNT, default 256, SHALL set the number of operands per sweep (1..65535).
REQ-004 Parameter SEED, default 0, SHALL set the first operand of each sweep.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 start  input  1  SHALL request a new sweep when high in IDLE.
REQ-008 x  output  WIDTH  SHALL drive the operand into the downstream add-one stage (registered).
REQ-009 y  input  WIDTH  SHALL carry the add-one stage's combinational result for x.
REQ-010 busy  output  1  SHALL be high in DRIVE and CHECK.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking sweep completion.
REQ-012 pass  output  1  SHALL be high when the last completed sweep had zero mismatches.
REQ-013 err_count  output  16  SHALL hold the mismatch count of the current/last sweep.
REQ-014 first_bad_x  output  WIDTH  SHALL hold the operand of the first mismatch of the current/last sweep.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
REQ-016 IDLE with start=1 SHALL: load x<=SEED, step counter<=0, err_count<=0, first_bad_x<=0, pass<=0, and go to DRIVE.
REQ-017 IDLE with start=0 SHALL hold all outputs.
REQ-018 DRIVE SHALL hold x stable for one cycle so y settles, then go to CHECK.
REQ-019 CHECK SHALL compare y against (x+1) mod 2^WIDTH; a mismatch SHALL increment err_count.
REQ-020 err_count SHALL saturate at 16'hFFFF, never wrap.
REQ-021 On the first mismatch of a sweep (err_count==0 before increment) first_bad_x SHALL capture x; later mismatches SHALL not change it.
REQ-022 CHECK with step counter < COUNT-1 SHALL: x<=(x+STRIDE) mod 2^WIDTH, counter++, go to DRIVE.
REQ-023 CHECK with step counter == COUNT-1 SHALL go to DONE with x unchanged.
REQ-024 DONE SHALL assert done for exactly one cycle, set pass<=(err_count==0) including this sweep's final check, go to IDLE.
REQ-025 Each operand SHALL occupy exactly 2 cycles; start sampled at edge 0 -> done high during cycle 2*COUNT+1 after that edge.
REQ-026 start SHALL be ignored in DRIVE, CHECK, DONE; start held high SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-027 Operand and expected-result arithmetic SHALL wrap modulo 2^WIDTH (x=255 expects y=0 at WIDTH=8).
REQ-028 err_count, first_bad_x, pass SHALL remain stable in IDLE until the next start.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, x=SEED, counter=0, busy=0, done=0, pass=0, err_count=0, first_bad_x=0.
REQ-030 Reset asserted mid-sweep SHALL abort it with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-031 Release of rst_n SHALL not itself start a sweep, even with start high, until the first rising edge in IDLE.

Verification
REQ-032 Correct add-one model, defaults, start pulse -> busy 512 cycles, done one pulse, err_count=0, pass=1, first_bad_x=0.
REQ-033 Model forcing y=0 -> err_count=255 (only x=255 matches), first_bad_x=0, pass=0.
REQ-034 Operand trace, defaults -> x = 0,17,34,...,238,255,16,33,...; all 256 values seen exactly once.
REQ-035 start pulsed at step 10 of a sweep -> ignored; done once, after 512 cycles from original start.
REQ-036 rst_n low at step 100 -> outputs at reset values immediately, no done; new start -> full clean sweep, pass=1.
REQ-037 COUNT=1, correct model -> x=SEED for 2 cycles, done at cycle 3, pass=1.
